sram_mem_arbiter: RTL and testbench

- Shares one single-port, synchronous-read data/instruction SRAM between two requesters.
- Requester 0 is the instruction fetch stage (read-only); requester 1 is the memory stage (read/write).
- Sequences each access with a programmable wait-state count and returns data via a req/ready handshake.
- Sits between the pipeline stages and the SRAM; a pending, unanswered request is what the pipeline's hazard/freeze logic stalls on.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/sram_wait_timer.sv | 30 +++
 rtl/sram_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM arbiter and its wait-state timer.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   // Grant encoding: which requester owns the current access
   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_WAIT_CYCLES = 2;

   // Counter width able to hold n (at least one bit so n = 0 still elaborates)
   function automatic int cnt_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state down-counter: loaded with WAIT_CYCLES on start, flags the last
// access cycle once it has counted down to zero.
module sram_wait_timer
   import mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic last_cycle
);

   localparam int CW = cnt_width(WAIT_CYCLES);

   logic [CW-1:0] cnt;

   // Load on start, then count down and park at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (start)
         cnt <= CW'(WAIT_CYCLES);
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign last_cycle = (cnt == '0);

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-port arbiter in front of one single-port SRAM: instruction fetch
// (read-only) and memory stage (read/write). Each access runs WAIT_CYCLES+1
// SRAM cycles followed by a one-cycle ready pulse to the granted port.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise the memory stage always wins.
module sram_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              busy
);

   arb_state_t        state, state_nxt;
   logic              grant_nxt;
   logic              gnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              start;
   logic              last_cycle;
   logic              any_req;

   // Byte-lane bits and bits above the SRAM depth are don't-cares
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               mem_addr[31:ADDR_W+2], mem_addr[1:0]};

   assign any_req = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Simultaneous requests go to whoever did not get the previous grant
   always_comb begin
      grant_nxt = mem_req ? GNT_MEM : GNT_IF;
      if (if_req && mem_req)
         grant_nxt = ~last_grant;
   end

   // Remember the most recent grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= GNT_IF;
      else if (state == IDLE && any_req)
         last_grant <= grant_nxt;
   end
`else
   // Fixed priority: the memory stage wins, fetch waits
   always_comb begin
      grant_nxt = mem_req ? GNT_MEM : GNT_IF;
   end
`endif

   sram_wait_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .last_cycle (last_cycle)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; the timer is armed on the grant edge
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = ACCESS;
               start     = 1'b1;
            end
         end
         ACCESS: begin
            if (last_cycle)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the granted request so the SRAM sees stable values all access long
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt     <= GNT_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state == IDLE && any_req) begin
         gnt <= grant_nxt;
         if (grant_nxt == GNT_MEM) begin
            addr_q  <= mem_addr[ADDR_W+1:2];
            we_q    <= mem_we;
            wdata_q <= mem_wdata;
         end else begin
            addr_q  <= if_addr[ADDR_W+1:2];
            we_q    <= 1'b0;
         end
      end
   end

   // Read data lands in the granted port on the final access cycle and holds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else if (state == ACCESS && last_cycle && !we_q) begin
         if (gnt == GNT_MEM)
            mem_rdata <= sram_rdata;
         else
            if_rdata  <= sram_rdata;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once
   assign sram_ce_n  = (state != ACCESS);
   assign sram_we_n  = !((state == ACCESS) && we_q);
   assign sram_oe_n  = !((state == ACCESS) && !we_q);
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

   assign if_ready  = (state == DONE) && (gnt == GNT_IF);
   assign mem_ready = (state == DONE) && (gnt == GNT_MEM);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Scoreboard bench for sram_mem_arbiter: a predictor derives grant order,
// access windows and read data from the latency/arbitration rules; a
// negedge monitor compares the DUT every cycle.
module tb_sram_mem_arbiter;

   localparam int AW = 16;
   localparam int W  = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [31:0]   if_addr = '0;
   logic [31:0]   if_rdata;
   logic          if_ready;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [31:0]   mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [31:0]   mem_rdata;
   logic          mem_ready;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;
   logic          sram_ce_n, sram_we_n, sram_oe_n, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sram_mem_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .busy(busy)
   );

   // SRAM device: write on clock edge, read data available while enabled
   logic [31:0] sram_mem [0:DEPTH-1];
   always @(posedge clk)
      if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_wdata;
   assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'hBAD0_BAD0;

   // Reference contents, updated in grant order
   logic [31:0] ref_mem [0:DEPTH-1];

   typedef struct {
      int          port;   // 0 = fetch, 1 = memory stage
      bit          we;
      int          word;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          g;      // cycle index of the grant edge
   } txn_t;

   txn_t sb[$];
   int   next_free = 0;
   int   model_last = 0;
   logic [31:0] hold_if = '0, hold_mem = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Predictor: sees the inputs the DUT samples on this edge
   always @(posedge clk) begin
      txn_t t;
      logic [31:0] a;
      cyc++;
      if (!rst) begin
         sb.delete();
         next_free  = 0;
         model_last = 0;
      end else if (cyc >= next_free && (if_req || mem_req)) begin
         if (if_req && mem_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            t.port = (model_last == 0) ? 1 : 0;
`else
            t.port = 1;
`endif
         end else begin
            t.port = mem_req ? 1 : 0;
         end
         model_last = t.port;
         a       = (t.port == 1) ? mem_addr : if_addr;
         t.we    = (t.port == 1) ? mem_we : 1'b0;
         t.word  = int'((a >> 2) % DEPTH);
         t.wdata = mem_wdata;
         t.g     = cyc;
         t.rdata = ref_mem[t.word];
         if (t.we) ref_mem[t.word] = t.wdata;
         sb.push_back(t);
         next_free = cyc + W + 3;
      end
   end

   // Monitor: compares strobes, busy, ready and held read data each cycle
   always @(negedge clk) begin
      txn_t h;
      bit act, done;
      act = 0;
      done = 0;
      h.port = 0; h.we = 0; h.word = 0; h.wdata = '0; h.rdata = '0; h.g = 0;
      if (!rst) begin
         hold_if  = '0;
         hold_mem = '0;
      end else begin
         while (sb.size() > 0 && sb[0].g + W + 1 < cyc) begin
            chk("ready_missing", 32'(sb[0].g), 32'(cyc));
            void'(sb.pop_front());
         end
         if (sb.size() > 0) begin
            h    = sb[0];
            act  = (cyc >= h.g) && (cyc <= h.g + W);
            done = (cyc == h.g + W + 1);
         end
         chk("strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}),
             32'({!act, !(act && h.we), !(act && !h.we)}));
         if (act) chk("sram_addr", 32'(sram_addr), 32'(h.word));
         if (act && h.we) chk("sram_wdata", sram_wdata, h.wdata);
         chk("busy", 32'(busy), 32'(act || done));
         if (done) begin
            if (!h.we) begin
               if (h.port == 1) hold_mem = h.rdata;
               else             hold_if  = h.rdata;
            end
            void'(sb.pop_front());
         end
         chk("if_ready", 32'(if_ready), 32'(done && h.port == 0));
         chk("mem_ready", 32'(mem_ready), 32'(done && h.port == 1));
         chk("if_rdata", if_rdata, hold_if);
         chk("mem_rdata", mem_rdata, hold_mem);
      end
   end

   // Requesters: called just after a rising edge; hold until ready, drop next edge
   task automatic if_access(input logic [31:0] a, output int rc);
      int n = 0;
      if_req  = 1'b1;
      if_addr = a;
      do begin @(negedge clk); n++; end while (!if_ready && n < 60);
      rc = cyc;
      if (!if_ready) chk("if_timeout", 32'(if_ready), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic mem_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                             output int rc);
      int n = 0;
      mem_req   = 1'b1;
      mem_we    = we;
      mem_addr  = a;
      mem_wdata = d;
      do begin @(negedge clk); n++; end while (!mem_ready && n < 60);
      rc = cyc;
      if (!mem_ready) chk("mem_timeout", 32'(mem_ready), 32'd1);
      @(posedge clk); #1;
      mem_req = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      return ($urandom() & 32'hFFFC_0000) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   task automatic if_agent(input int n, input int gap_max);
      int rc;
      repeat (n) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         if_access(rand_addr(), rc);
      end
   endtask

   task automatic mem_agent(input int n, input int gap_max);
      int rc;
      repeat (n) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         mem_access(1'($urandom_range(0, 1)), rand_addr(), $urandom(), rc);
      end
   endtask

   initial begin
      int t_if, t_mem, rc;
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom();
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      sram_mem[4] = 32'hE3A0_1005;
      ref_mem[4]  = 32'hE3A0_1005;

      // Reset state
      #12;
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'd7);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_sram_wdata", sram_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // Fetch of word 4
      if_access(32'h0000_0010, rc);
      chk("fetch_word4", if_rdata, 32'hE3A0_1005);

      // Write then read back through the memory stage
      mem_access(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, rc);
      chk("rdata_after_write", mem_rdata, 32'd0);
      mem_access(1'b0, 32'h0000_0020, 32'h0, rc);
      chk("readback", mem_rdata, 32'hDEAD_BEEF);

      // Simultaneous requests
      fork
         if_access(32'h0000_0014, t_if);
         mem_access(1'b0, 32'h0000_0024, 32'h0, t_mem);
      join
`ifdef ARB_ROUND_ROBIN_EN
      chk("simul_spacing", 32'(t_mem - t_if), 32'(W + 3));
`else
      chk("simul_spacing", 32'(t_if - t_mem), 32'(W + 3));
`endif

      // Address wrap: upper bits dropped
      if_access(32'h0004_0008, rc);
      chk("wrap_rdata", if_rdata, ref_mem[2]);

      // Randomized traffic, then both requesters held continuously
      fork
         if_agent(40, 3);
         mem_agent(40, 3);
      join
      fork
         if_agent(8, 0);
         mem_agent(8, 0);
      join

      // Reset during the second access cycle of a write
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'h1234_5678;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      mem_req = 1'b0;
      #1;
      chk("midrst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'd7);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      if_access(32'h0000_0018, rc);
      chk("post_rst_fetch", if_rdata, ref_mem[6]);
      repeat (4) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
